// File: rtl/tpsram_fifo_pkg.sv
// Shared helpers for tpsram_fifo: address-width derivation and parameter-legality checks.
package tpsram_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 32;
  localparam int unsigned MIN_DEPTH     = 4;
  localparam int unsigned MAX_DEPTH     = 4096;
  localparam int unsigned MAX_WIDTH     = 64;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Address width of the storage array; never below one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned depth,
                                      input int unsigned af_level,
                                      input int unsigned ae_level);
    return (width >= 1) && (width <= MAX_WIDTH) && is_pow2(depth) &&
           (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) &&
           (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/tpsram_fifo_mem.sv
// Inferred simple dual-port RAM (one write port, one registered read port).
// The read register holds its value when ren is low; array contents are not reset.
module tpsram_fifo_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wd,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wen) mem_q[waddr] <= wd;
  end

  // Registered read port; holds when not reading.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_q <= '0;
    end else if (ren) begin
      rd_q <= mem_q[raddr];
    end
  end

  assign rd = rd_q;

endmodule

// File: rtl/tpsram_fifo.sv
// Single-clock synchronous FIFO over an inferred two-port RAM, with registered occupancy,
// almost-flags and sticky overflow/underflow errors.
// Optional macro TPSRAM_FIFO_OUTREG_EN adds an output pipeline stage (read latency 2).
module tpsram_fifo
  import tpsram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4,
  localparam int unsigned AW      = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr,
  input  logic             wen,
  input  logic [WIDTH-1:0] wd,
  input  logic             ren,
  output logic [WIDTH-1:0] rd,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_LVL     = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_LVL     = AE_LEVEL[AW:0];
  localparam bit          AF_AT_ZERO = (AF_LEVEL == 0);

  if (!params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : gen_bad_params
    $error("tpsram_fifo: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        af_q, af_d;
  logic        ae_q, ae_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        rd_acc, wr_acc;
  logic        push, pop;
  logic [WIDTH-1:0] ram_rd;

  // Acceptance, pointer advance, sticky errors and next-state flags.
  always_comb begin
    rd_acc   = ren & ~empty_q;
    // Push at full is only legal when a pop frees a slot in the same cycle.
    wr_acc   = wen & (~full_q | rd_acc);
    push     = wr_acc & ~clr;
    pop      = rd_acc & ~clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wen & full_q & ~rd_acc) ovf_d = 1'b1;
      if (ren & empty_q) udf_d = 1'b1;
    end
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    af_d    = (count_d >= AF_LVL);
    ae_d    = (count_d <= AE_LVL);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= AF_AT_ZERO;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  tpsram_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .arst  (arst),
    .wen   (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wd    (wd),
    .ren   (pop),
    .raddr (rd_ptr_q[AW-1:0]),
    .rd    (ram_rd)
  );

`ifdef TPSRAM_FIFO_OUTREG_EN
  logic             stage_valid_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_q;

  // Output pipeline stage; CLR drops any word still travelling through it.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stage_valid_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_q          <= '0;
    end else begin
      stage_valid_q <= pop;
      rd_valid_q    <= stage_valid_q & ~clr;
      if (stage_valid_q & ~clr) rd_q <= ram_rd;
    end
  end

  assign rd = rd_q;
`else
  logic rd_valid_q;

  // One-cycle valid pulse aligned with the RAM read register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
    end
  end

  assign rd = ram_rd;
`endif

  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

endmodule

// File: tb/tb_tpsram_fifo.sv
// Self-checking bench for tpsram_fifo: directed scenarios plus random traffic, compared each
// cycle against a queue-based reference model.
module tb_tpsram_fifo;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DEPTH    = 32;
  localparam int unsigned AF_LEVEL = 28;
  localparam int unsigned AE_LEVEL = 4;
  localparam int unsigned AW       = 5;
`ifdef TPSRAM_FIFO_OUTREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             arst, clr, wen, ren;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             rd_valid, full, empty, almost_full, almost_empty, ovf, udf;
  logic [AW:0]      count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf, m_udf;
  logic [WIDTH-1:0] m_rd;
  bit               pv[LAT];
  logic [WIDTH-1:0] pd[LAT];

  tpsram_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .clr          (clr),
    .wen          (wen),
    .wd           (wd),
    .ren          (ren),
    .rd           (rd),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .ovf          (ovf),
    .udf          (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"}, 64'(count), 64'(n));
    check({tag, ".full"}, 64'(full), 64'(n == DEPTH));
    check({tag, ".empty"}, 64'(empty), 64'(n == 0));
    check({tag, ".almost_full"}, 64'(almost_full), 64'(n >= AF_LEVEL));
    check({tag, ".almost_empty"}, 64'(almost_empty), 64'(n <= AE_LEVEL));
    check({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
    check({tag, ".udf"}, 64'(udf), 64'(m_udf));
    check({tag, ".rd_valid"}, 64'(rd_valid), 64'(pv[LAT-1]));
    check({tag, ".rd"}, 64'(rd), 64'(m_rd));
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rd  = '0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endfunction

  // One clock of FIFO behaviour derived from occupancy rules, not from the RTL structure.
  function automatic void model_apply(input bit w, input logic [WIDTH-1:0] d, input bit r,
                                      input bit c);
    int               n;
    bit               racc, wacc;
    logic [WIDTH-1:0] popped;
    n      = mq.size();
    popped = '0;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
    end else begin
      racc = r && (n > 0);
      wacc = w && ((n < DEPTH) || racc);
      if (w && (n == DEPTH) && !racc) m_ovf = 1'b1;
      if (r && (n == 0)) m_udf = 1'b1;
      if (racc) popped = mq.pop_front();
      if (wacc) mq.push_back(d);
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = racc;
      pd[0] = popped;
    end
    if (pv[LAT-1]) m_rd = pd[LAT-1];
  endfunction

  task automatic step(input string tag, input bit w, input logic [WIDTH-1:0] d, input bit r,
                      input bit c);
    @(negedge clk);
    wen = w;
    wd  = d;
    ren = r;
    clr = c;
    model_apply(w, d, r, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned wp, rp;
    arst = 1'b1;
    clr  = 1'b0;
    wen  = 1'b0;
    ren  = 1'b0;
    wd   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    arst = 1'b0;

    // Fill 0x0000..0x001F, then a dropped push at full.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, WIDTH'(i), 1'b0, 1'b0);
    step("ovf_push", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    idle("ovf_sticky");

    // Drain all, then a pop while empty.
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < LAT; i++) idle("drain_tail");
    step("udf_pop", 1'b0, '0, 1'b1, 1'b0);
    idle("udf_sticky");
    step("clr_err", 1'b0, '0, 1'b0, 1'b1);

    // Full, then simultaneous push/pop across pointer wrap.
    for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("full_rw", 1'b1, WIDTH'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0);
    step("empty_rw", 1'b1, 16'h1234, 1'b1, 1'b0);
    idle("empty_rw_after");

    // CLR with a same-cycle push while 10 words queued.
    step("pre_clr", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step("q10", 1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    step("clr_wen", 1'b1, 16'hCAFE, 1'b0, 1'b1);
    idle("clr_after");

    // CLR right after a pop: the popped word must not be delivered late.
    step("pp1", 1'b1, 16'h00A1, 1'b0, 1'b0);
    step("pp2", 1'b1, 16'h00A2, 1'b0, 1'b0);
    step("pop_then_clr", 1'b0, '0, 1'b1, 1'b0);
    step("clr_between", 1'b0, '0, 1'b0, 1'b1);
    idle("clr_between_after");

    // Random traffic in phases biased towards filling, draining, then balanced.
    for (int ph = 0; ph < 3; ph++) begin
      wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      rp = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
      for (int i = 0; i < 150; i++) begin
        step("rand", ($urandom_range(0, 99) < wp), WIDTH'($urandom),
             ($urandom_range(0, 99) < rp), ($urandom_range(0, 99) < 2));
      end
    end

    // Async reset mid-stream with 5 words queued and a pop in flight.
    step("pre_arst", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step("q5", 1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    step("inflight_pop", 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    wen  = 1'b0;
    ren  = 1'b0;
    clr  = 1'b0;
    arst = 1'b1;
    #1;
    model_reset();
    check_all("arst_async");
    @(posedge clk);
    #1;
    check_all("arst_held");
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 5; i++) step("post_arst", 1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("post_arst_pop", 1'b0, '0, 1'b1, 1'b0);
    idle("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tpsram_fifo.md
Name: tpsram_fifo

Overview:
- Parametrised single-clock synchronous FIFO built on an inferred two-port SRAM (one write port, one read port).
- Successor to the fixed 32x16 two-port RAM core. Adds configurable width and depth, pointer management, occupancy count, programmable almost-flags, and sticky overflow/underflow errors.
- Used as the command/sample buffer between the host interface and the DM drive sequencers.

Parameters:
- WIDTH, 16, data word width in bits (1..64)
- DEPTH, 32, number of words; power of two, 4..4096
- AF_LEVEL, DEPTH-4, ALMOST_FULL asserts when COUNT >= AF_LEVEL
- AE_LEVEL, 4, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL

Ports:
- CLK  in  1  sole clock, rising edge
- ARST  in  1  asynchronous reset, active-high
- CLR  in  1  synchronous flush, active-high
- WEN  in  1  push request
- WD  in  WIDTH  push data
- REN  in  1  pop request
- RD  out  WIDTH  pop data
- RD_VALID  out  1  RD holds newly popped word this cycle
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL
- COUNT  out  AW+1  occupancy, AW = clog2(DEPTH)
- OVF  out  1  sticky: push attempted while full and not popping
- UDF  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (ARST high, async) forces: pointers=0, COUNT=0, RD=0, RD_VALID=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0 (0 unless AF_LEVEL==0), OVF=0, UDF=0.
- RAM contents are not reset. A pop in flight at reset assertion is discarded.
- Pointers:
  - wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit.
  - FULL when addresses are equal and wrap bits differ; EMPTY when pointers are equal.
  - COUNT = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Pop acceptance: rd_acc = REN & ~EMPTY.
- Push acceptance: wr_acc = WEN & (~FULL | rd_acc). A simultaneous push and pop at full is legal and COUNT stays DEPTH.
- Simultaneous push and pop when empty: push is accepted, pop is rejected and sets UDF. The RAM never has to return a word written in the same cycle.
- Read latency:
  - rd_acc in cycle N gives RD = mem[rd_ptr] and RD_VALID=1 in cycle N+1.
  - RD holds its value when there is no pop; RD_VALID is a one-cycle pulse per accepted pop.
- Write: on wr_acc, mem[wr_ptr] <= WD and wr_ptr increments, wrapping DEPTH-1 -> 0 with the wrap bit toggling.
- All flags and COUNT are registered and reflect state after the edge. FULL/EMPTY update in the same cycle as the pointer.
- OVF sets on WEN & FULL & ~rd_acc. UDF sets on REN & EMPTY. Both clear only on ARST or CLR.
- CLR (sync) has the same effect as reset on pointers, flags, OVF/UDF and RD_VALID; RD holds. CLR takes priority over a same-cycle WEN/REN.
- No state machine beyond the pointer/flag registers; the rejected-op rules above are exhaustive.

Optional Feature:
- Macro: TPSRAM_FIFO_OUTREG_EN.
- Defined:
  - Adds an output pipeline register after the RAM read port, matching the pipelined SRAM read mode.
  - Read latency becomes 2 (rd_acc in N gives RD/RD_VALID in N+2).
  - The pipeline stage is cleared by ARST and CLR (RD_VALID=0).
  - Flags are unchanged, since they track accepted pops, not data delivery.
- Undefined: latency 1 as above.

Decomposition:
- Package tpsram_fifo_pkg:
  - clog2 function
  - AW derivation
  - parameter-legality check constants: DEPTH power of two, AE_LEVEL < AF_LEVEL <= DEPTH
- Sub-module tpsram_fifo_mem:
  - Inferred simple dual-port RAM: WIDTH x DEPTH, WEN/WADDR/WD, REN/RADDR/RD, registered read.
  - Holds RD when REN is low.
  - Maps to LSRAM/uSRAM.

Test Plan:
- Reset/idle: assert ARST mid-stream with 5 words queued -> COUNT=0, EMPTY=1, RD=0, RD_VALID=0, OVF=UDF=0 immediately, before the next edge.
- Fill/drain, WIDTH=16, DEPTH=32: push 0x0000..0x001F -> FULL=1 after the 32nd push, ALMOST_FULL from COUNT=28. Pop 32 -> RD sequence 0x0000..0x001F, each one cycle after REN. EMPTY=1, ALMOST_EMPTY from COUNT=4.
- Overflow/underflow: push 0xBEEF when full with REN=0 -> data dropped, OVF=1 sticky. Pop when empty -> UDF=1, RD_VALID=0, RD unchanged.
- Simultaneous ops: at full, WEN+REN for 40 cycles -> COUNT stays 32, no OVF, data order preserved across pointer wrap. At empty, WEN+REN -> COUNT=1, UDF=1.
- CLR: with 10 words queued, pulse CLR together with WEN -> COUNT=0, EMPTY=1, OVF/UDF cleared, the same-cycle push discarded.
- OUTREG build (TPSRAM_FIFO_OUTREG_EN): repeat the fill/drain scenario -> RD lags REN by exactly 2 cycles; CLR in the cycle between -> no RD_VALID pulse.
